// File: rtl/int_issue_queue.sv
// Integer issue queue: collapsing, oldest-ready select, CDB wakeup with dispatch bypass.
// Optional INT_IQ_STATS_EN adds saturating issued / full-stall counters.
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         disp_en,
  input  logic [OP_W-1:0]              disp_op,
  input  logic                         disp_rs1_rdy,
  input  logic [TAG_W-1:0]             disp_rs1_tag,
  input  logic [DATA_W-1:0]            disp_rs1_data,
  input  logic                         disp_rs2_rdy,
  input  logic [TAG_W-1:0]             disp_rs2_tag,
  input  logic [DATA_W-1:0]            disp_rs2_data,
  input  logic [TAG_W-1:0]             disp_rd_tag,
  output logic                         queue_full,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         ready_int,
  input  logic                         issue_int,
  output logic [OP_W-1:0]              iss_op,
  output logic [DATA_W-1:0]            iss_rs1_data,
  output logic [DATA_W-1:0]            iss_rs2_data,
  output logic [TAG_W-1:0]             iss_rd_tag,
  output logic [$clog2(DEPTH+1)-1:0]   dbg_count_o
`ifdef INT_IQ_STATS_EN
  ,
  output logic [31:0]                  stat_issued,
  output logic [31:0]                  stat_full_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic              rs1_rdy;
    logic [TAG_W-1:0]  rs1_tag;
    logic [DATA_W-1:0] rs1_data;
    logic              rs2_rdy;
    logic [TAG_W-1:0]  rs2_tag;
    logic [DATA_W-1:0] rs2_data;
    logic [TAG_W-1:0]  rd_tag;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            new_ent;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  wr_idx;
  logic [DEPTH-1:0]  shift_mask;
  logic              issue_acc;
  logic              disp_acc;

  // Operand capture from the CDB; also used for the dispatch bypass.
  function automatic entry_t wake(input entry_t e, input logic cv,
                                  input logic [TAG_W-1:0] ct,
                                  input logic [DATA_W-1:0] cd);
    entry_t r;
    r = e;
    if (cv && e.valid && !e.rs1_rdy && (e.rs1_tag == ct)) begin
      r.rs1_rdy  = 1'b1;
      r.rs1_data = cd;
    end
    if (cv && e.valid && !e.rs2_rdy && (e.rs2_tag == ct)) begin
      r.rs2_rdy  = 1'b1;
      r.rs2_data = cd;
    end
    return r;
  endfunction

  assign queue_full  = (count_q == CNT_W'(DEPTH));
  assign dbg_count_o = count_q;

  // Oldest-ready select; shift_mask marks the selected slot and every slot above it.
  always_comb begin
    logic found;
    found        = 1'b0;
    shift_mask   = '0;
    iss_op       = '0;
    iss_rs1_data = '0;
    iss_rs2_data = '0;
    iss_rd_tag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        found        = 1'b1;
        iss_op       = ent_q[i].op;
        iss_rs1_data = ent_q[i].rs1_data;
        iss_rs2_data = ent_q[i].rs2_data;
        iss_rd_tag   = ent_q[i].rd_tag;
      end
      shift_mask[i] = found;
    end
    ready_int = found;
  end

  always_comb begin
    issue_acc = issue_int && ready_int;
    disp_acc  = disp_en && !queue_full;
    wr_idx    = count_q - CNT_W'(issue_acc);

    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.op       = disp_op;
    new_ent.rs1_rdy  = disp_rs1_rdy;
    new_ent.rs1_tag  = disp_rs1_tag;
    new_ent.rs1_data = disp_rs1_data;
    new_ent.rs2_rdy  = disp_rs2_rdy;
    new_ent.rs2_tag  = disp_rs2_tag;
    new_ent.rs2_data = disp_rs2_data;
    new_ent.rd_tag   = disp_rd_tag;
    new_ent          = wake(new_ent, cdb_valid, cdb_tag, cdb_data);

    for (int i = 0; i < DEPTH - 1; i++) begin
      if (issue_acc && shift_mask[i]) ent_d[i] = wake(ent_q[i+1], cdb_valid, cdb_tag, cdb_data);
      else                            ent_d[i] = wake(ent_q[i], cdb_valid, cdb_tag, cdb_data);
    end
    if (issue_acc && shift_mask[DEPTH-1]) ent_d[DEPTH-1] = '0;
    else ent_d[DEPTH-1] = wake(ent_q[DEPTH-1], cdb_valid, cdb_tag, cdb_data);

    for (int i = 0; i < DEPTH; i++) begin
      if (disp_acc && (wr_idx == CNT_W'(i))) ent_d[i] = new_ent;
    end

    count_d = count_q + CNT_W'(disp_acc) - CNT_W'(issue_acc);

    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

`ifdef INT_IQ_STATS_EN
  // Counters survive a flush; a flushed issue is not an accepted issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stat_issued     <= '0;
      stat_full_stall <= '0;
    end else begin
      if (issue_acc && !i_flush && (stat_issued != 32'hFFFF_FFFF))
        stat_issued <= stat_issued + 32'd1;
      if (disp_en && queue_full && (stat_full_stall != 32'hFFFF_FFFF))
        stat_full_stall <= stat_full_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: wakeup, bypass, collapse order, full drop, flush.
module tb_int_issue_queue;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        disp_en;
  logic [3:0]  disp_op;
  logic        disp_rs1_rdy;
  logic [5:0]  disp_rs1_tag;
  logic [31:0] disp_rs1_data;
  logic        disp_rs2_rdy;
  logic [5:0]  disp_rs2_tag;
  logic [31:0] disp_rs2_data;
  logic [5:0]  disp_rd_tag;
  logic        queue_full;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        ready_int;
  logic        issue_int;
  logic [3:0]  iss_op;
  logic [31:0] iss_rs1_data;
  logic [31:0] iss_rs2_data;
  logic [5:0]  iss_rd_tag;
  logic [2:0]  dbg_count_o;
`ifdef INT_IQ_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_full_stall;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  int_issue_queue dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .disp_en(disp_en), .disp_op(disp_op),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_data(disp_rs1_data),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_data(disp_rs2_data),
    .disp_rd_tag(disp_rd_tag), .queue_full(queue_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ready_int(ready_int), .issue_int(issue_int), .iss_op(iss_op),
    .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data), .iss_rd_tag(iss_rd_tag),
    .dbg_count_o(dbg_count_o)
`ifdef INT_IQ_STATS_EN
    , .stat_issued(stat_issued), .stat_full_stall(stat_full_stall)
`endif
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr();
    i_flush = 0; disp_en = 0; disp_op = 0;
    disp_rs1_rdy = 0; disp_rs1_tag = 0; disp_rs1_data = 0;
    disp_rs2_rdy = 0; disp_rs2_tag = 0; disp_rs2_data = 0;
    disp_rd_tag = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0; issue_int = 0;
  endtask

  task automatic set_disp(input logic [3:0] op,
                          input logic r1_rdy, input logic [5:0] r1_tag, input logic [31:0] r1_d,
                          input logic r2_rdy, input logic [5:0] r2_tag, input logic [31:0] r2_d,
                          input logic [5:0] rd);
    disp_en = 1; disp_op = op;
    disp_rs1_rdy = r1_rdy; disp_rs1_tag = r1_tag; disp_rs1_data = r1_d;
    disp_rs2_rdy = r2_rdy; disp_rs2_tag = r2_tag; disp_rs2_data = r2_d;
    disp_rd_tag = rd;
  endtask

  task automatic set_cdb(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = 1; cdb_tag = tag; cdb_data = data;
  endtask

  task automatic do_issue();
    issue_int = 1; tick(); clr();
  endtask

  initial begin
    clr();
    i_rst_n = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ready", {31'b0, ready_int}, 0);
    check("rst_full", {31'b0, queue_full}, 0);
    check("rst_count", {29'b0, dbg_count_o}, 0);
    check("rst_iss_rd", {26'b0, iss_rd_tag}, 0);
    check("rst_iss_rs1", iss_rs1_data, 0);
    check("rst_iss_op", {28'b0, iss_op}, 0);
    i_rst_n = 1;
    tick();

    // A: both ready
    set_disp(4'd1, 1, 0, 32'h11, 1, 0, 32'h22, 6'd5); tick(); clr();
    check("a_ready", {31'b0, ready_int}, 1);
    check("a_rd", {26'b0, iss_rd_tag}, 5);
    check("a_rs1", iss_rs1_data, 32'h11);
    check("a_rs2", iss_rs2_data, 32'h22);
    check("a_op", {28'b0, iss_op}, 1);
    check("a_count", {29'b0, dbg_count_o}, 1);
    do_issue();
    check("a_cnt_post", {29'b0, dbg_count_o}, 0);
    check("a_rdy_post", {31'b0, ready_int}, 0);
    check("a_rd_post", {26'b0, iss_rd_tag}, 0);

    // B: CDB wakeup; issue while not ready is ignored
    set_disp(4'd2, 0, 6'd9, 0, 1, 0, 32'h5, 6'd7); tick(); clr();
    check("b_not_ready", {31'b0, ready_int}, 0);
    issue_int = 1; set_cdb(6'd9, 32'h1234); tick(); clr();
    check("b_ready", {31'b0, ready_int}, 1);
    check("b_rs1", iss_rs1_data, 32'h1234);
    check("b_count", {29'b0, dbg_count_o}, 1);
    check("b_rd", {26'b0, iss_rd_tag}, 7);
    do_issue();

    // C: dispatch bypass
    set_disp(4'd3, 1, 0, 32'h1, 0, 6'd3, 0, 6'd8); set_cdb(6'd3, 32'hBEEF); tick(); clr();
    check("c_ready", {31'b0, ready_int}, 1);
    check("c_rs2", iss_rs2_data, 32'hBEEF);
    do_issue();

    // D: same tag on both operands, wrong tag first
    set_disp(4'd7, 0, 6'd12, 0, 0, 6'd12, 0, 6'd9); tick(); clr();
    check("d_not_ready", {31'b0, ready_int}, 0);
    set_cdb(6'd13, 32'h99); tick(); clr();
    check("d_wrong_tag", {31'b0, ready_int}, 0);
    set_cdb(6'd12, 32'h77); tick(); clr();
    check("d_ready", {31'b0, ready_int}, 1);
    check("d_rs1", iss_rs1_data, 32'h77);
    check("d_rs2", iss_rs2_data, 32'h77);
    do_issue();

    // Fill: only entry 2 ready
    set_disp(4'd3, 0, 6'd30, 0, 1, 0, 32'h100, 6'd20); tick();
    set_disp(4'd3, 0, 6'd31, 0, 1, 0, 32'h101, 6'd21); tick();
    set_disp(4'd4, 1, 0, 32'hA2, 1, 0, 32'hB2, 6'd22); tick();
    set_disp(4'd3, 0, 6'd33, 0, 1, 0, 32'h103, 6'd23); tick(); clr();
    check("f_count", {29'b0, dbg_count_o}, 4);
    check("f_full", {31'b0, queue_full}, 1);
    check("f_rd", {26'b0, iss_rd_tag}, 22);
    check("f_rs1", iss_rs1_data, 32'hA2);
    set_disp(4'd1, 1, 0, 1, 1, 0, 1, 6'd60); tick(); clr();
    check("f_drop_cnt", {29'b0, dbg_count_o}, 4);
    check("f_drop_rd", {26'b0, iss_rd_tag}, 22);
    issue_int = 1; set_disp(4'd1, 1, 0, 1, 1, 0, 1, 6'd61); tick(); clr();
    check("f_iss_cnt", {29'b0, dbg_count_o}, 3);
    check("f_iss_full", {31'b0, queue_full}, 0);
    check("f_iss_rdy", {31'b0, ready_int}, 0);
    set_cdb(6'd33, 32'h3333); tick(); clr();
    check("f_shift_rd", {26'b0, iss_rd_tag}, 23);
    check("f_shift_rs1", iss_rs1_data, 32'h3333);
    do_issue();
    check("f_cnt2", {29'b0, dbg_count_o}, 2);

    // Oldest-ready: entries 1 and 3 ready
    set_disp(4'd5, 0, 6'd34, 0, 1, 0, 32'h104, 6'd24); tick();
    set_disp(4'd5, 1, 0, 32'h55, 1, 0, 32'h66, 6'd25); tick(); clr();
    check("o_cnt", {29'b0, dbg_count_o}, 4);
    check("o_only3", {26'b0, iss_rd_tag}, 25);
    set_cdb(6'd31, 32'h3131); tick(); clr();
    exp_q.push_back(32'd21);
    exp_q.push_back(32'd25);
    check("o_first", {26'b0, iss_rd_tag}, exp_q.pop_front());
    check("o_first_rs1", iss_rs1_data, 32'h3131);
    do_issue();
    check("o_second", {26'b0, iss_rd_tag}, exp_q.pop_front());
    check("o_cnt3", {29'b0, dbg_count_o}, 3);
    do_issue();
    check("o_cnt2", {29'b0, dbg_count_o}, 2);
    check("o_none", {31'b0, ready_int}, 0);

    // Flush over full + dispatch + issue
    set_disp(4'd1, 1, 0, 1, 1, 0, 2, 6'd26); tick();
    set_disp(4'd1, 1, 0, 3, 1, 0, 4, 6'd27); tick(); clr();
    check("fl_full", {31'b0, queue_full}, 1);
    check("fl_rd", {26'b0, iss_rd_tag}, 26);
    i_flush = 1; issue_int = 1; set_disp(4'd1, 1, 0, 5, 1, 0, 6, 6'd28); tick(); clr();
    check("fl_cnt", {29'b0, dbg_count_o}, 0);
    check("fl_full0", {31'b0, queue_full}, 0);
    check("fl_rdy", {31'b0, ready_int}, 0);
    check("fl_rd0", {26'b0, iss_rd_tag}, 0);
`ifdef INT_IQ_STATS_EN
    check("fl_stat_iss", stat_issued, 8);
    check("fl_stat_stall", stat_full_stall, 3);
`endif

    // Dispatch + issue same cycle lands at count-1
    set_disp(4'd2, 1, 0, 7, 1, 0, 8, 6'd40); tick(); clr();
    issue_int = 1; set_disp(4'd6, 1, 0, 9, 1, 0, 10, 6'd41); tick(); clr();
    check("di_cnt", {29'b0, dbg_count_o}, 1);
    check("di_rd", {26'b0, iss_rd_tag}, 41);
    check("di_op", {28'b0, iss_op}, 6);
    do_issue();

    // Wakeup of an entry shifting down in the same cycle
    set_disp(4'd2, 1, 0, 1, 1, 0, 1, 6'd50); tick();
    set_disp(4'd2, 0, 6'd15, 0, 1, 0, 32'h7, 6'd51); tick(); clr();
    check("sw_rd", {26'b0, iss_rd_tag}, 50);
    issue_int = 1; set_cdb(6'd15, 32'hCAFE); tick(); clr();
    check("sw_ready", {31'b0, ready_int}, 1);
    check("sw_rd2", {26'b0, iss_rd_tag}, 51);
    check("sw_rs1", iss_rs1_data, 32'hCAFE);
    check("sw_cnt", {29'b0, dbg_count_o}, 1);
    do_issue();
    check("sw_cnt0", {29'b0, dbg_count_o}, 0);
`ifdef INT_IQ_STATS_EN
    check("end_stat_iss", stat_issued, 12);
    check("end_stat_stall", stat_full_stall, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
